hex_scan: RTL

HEX_SCAN -- requirements
Module: hex_scan

---
 rtl/hex_scan_if.sv | 25 ++
 rtl/hex_scan.sv | 82 ++++++++
 2 files changed

// File: rtl/hex_scan_if.sv
// Display bus between a value source and the hex_scan digit multiplexer.
// Carries the load request/data and the scanned digit, enables and frame pulse.
interface hex_scan_if;
  logic        load;
  logic [15:0] data;
  logic [3:0]  nibble;
  logic [3:0]  an;
  logic        frame;

  modport master (
    output load,
    output data,
    input  nibble,
    input  an,
    input  frame
  );

  modport slave (
    input  load,
    input  data,
    output nibble,
    output an,
    output frame
  );
endinterface

// File: rtl/hex_scan.sv
// Four-digit multiplexed hex display scanner with tear-free frame-boundary updates.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module hex_scan #(
  parameter int unsigned DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  hex_scan_if.slave  bus
);

  localparam int unsigned    CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg,       cnt_next;
  logic [1:0]    idx_reg,       idx_next;
  logic [15:0]   pend_reg,      pend_next;
  logic          pend_flag_reg, pend_flag_next;
  logic [15:0]   disp_reg,      disp_next;
  logic          frame_reg,     frame_next;

  logic tick;
  logic frame_end;
  logic commit;

  always_comb begin
    tick      = (cnt_reg == CNT_LAST);
    cnt_next  = tick ? '0 : cnt_reg + 1'b1;
    idx_next  = tick ? idx_reg + 2'd1 : idx_reg;
    frame_end = tick && (idx_reg == 2'd3);
    commit    = frame_end && pend_flag_reg;

    // A load on the commit edge replaces the value being committed as the new pending one.
    disp_next      = commit ? pend_reg : disp_reg;
    frame_next     = commit;
    pend_next      = bus.load ? bus.data : pend_reg;
    pend_flag_next = bus.load | (pend_flag_reg & ~commit);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      idx_reg       <= 2'd0;
      pend_reg      <= 16'h0000;
      pend_flag_reg <= 1'b0;
      disp_reg      <= 16'h0000;
      frame_reg     <= 1'b0;
    end else begin
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      pend_reg      <= pend_next;
      pend_flag_reg <= pend_flag_next;
      disp_reg      <= disp_next;
      frame_reg     <= frame_next;
    end
  end

  logic [3:0] an_onehot;

  assign an_onehot  = ~(4'b0001 << idx_reg);
  assign bus.nibble = disp_reg[4*idx_reg +: 4];
  assign bus.frame  = frame_reg;

`ifdef LEADING_ZERO_BLANK_EN
  // lead_zero[k]: nibble k and every higher nibble are zero; digit 0 is never blanked.
  logic [3:0] lead_zero;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lead_zero
    if (gi == 0) begin : g_digit0
      assign lead_zero[gi] = 1'b0;
    end else if (gi == 3) begin : g_top
      assign lead_zero[gi] = (disp_reg[4*gi +: 4] == 4'h0);
    end else begin : g_mid
      assign lead_zero[gi] = (disp_reg[4*gi +: 4] == 4'h0) && lead_zero[gi+1];
    end
  end

  assign bus.an = lead_zero[idx_reg] ? 4'b1111 : an_onehot;
`else
  assign bus.an = an_onehot;
`endif

endmodule
